// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases a chain of reset domains one at a time, waiting
// for each to report ready, with bounded retries and a latched fault.
module rst_seq_ctrl #(
    parameter int N_STAGES    = 4,
    parameter int GAP_CYCLES  = 16000,
    parameter int ACK_TIMEOUT = 160000,
    parameter int MAX_RETRIES = 3,
    localparam int SW = $clog2(N_STAGES),
    localparam int RW = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                soft_rst_req,
    input  logic [N_STAGES-1:0] stage_ready,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                all_ready,
    output logic                busy,
    output logic                fault,
    output logic [SW-1:0]       fault_stage,
    output logic [RW-1:0]       retry_cnt
);
    localparam int TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int TW = $clog2(TMAX);
    // The one-cycle RELEASE state is part of the gap, so the count ends early.
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(N_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        WAIT_READY,
        GAP,
        RUN,
        FAULT
    } state_t;

    state_t              state;
    logic [SW-1:0]       idx;
    logic [TW-1:0]       timer;
    logic [N_STAGES-1:0] sync1;
    logic [N_STAGES-1:0] sync2;
    logic [N_STAGES-1:0] acked;
    logic [N_STAGES-1:0] lost;
    logic                lost_any;
    logic                fail;
    logic [SW-1:0]       lost_idx;
    logic [SW-1:0]       fail_idx;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= stage_ready;
            sync2 <= sync1;
        end
    end

    always_comb begin
        acked = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (state == RUN) acked[i] = 1'b1;
            else if (state == GAP) acked[i] = (i <= int'(idx));
            else if (state == WAIT_READY) acked[i] = (i < int'(idx));
        end
        lost = acked & ~sync2;
        lost_any = |lost;
        lost_idx = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (lost[i]) lost_idx = SW'(i);
        end
        fail = ((state == WAIT_READY || state == GAP) && lost_any) ||
               (state == WAIT_READY && !sync2[idx] && timer == ACK_LAST);
        fail_idx = lost_any ? lost_idx : idx;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            idx         <= '0;
            timer       <= '0;
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
            fault       <= 1'b0;
            fault_stage <= '0;
            retry_cnt   <= '0;
        end else if (soft_rst_req) begin
            state       <= HOLD;
            idx         <= '0;
            timer       <= '0;
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
            fault       <= 1'b0;
            retry_cnt   <= '0;
        end else if (fail) begin
            fault_stage <= fail_idx;
            stage_rst_n <= '0;
            idx         <= '0;
            timer       <= '0;
            if (int'(retry_cnt) < MAX_RETRIES) begin
                retry_cnt <= retry_cnt + RW'(1);
                state     <= HOLD;
            end else begin
                fault <= 1'b1;
                busy  <= 1'b0;
                state <= FAULT;
            end
        end else begin
            unique case (state)
                HOLD: begin
                    if (timer >= GAP_LAST) begin
                        idx   <= '0;
                        timer <= '0;
                        state <= RELEASE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RELEASE: begin
                    stage_rst_n[idx] <= 1'b1;
                    timer            <= '0;
                    state            <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (sync2[idx]) begin
                        timer <= '0;
                        if (idx == IDX_LAST) begin
                            all_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= RUN;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer >= GAP_LAST) begin
                        idx   <= idx + SW'(1);
                        timer <= '0;
                        state <= RELEASE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RUN: begin
                    // A domain dropping out after bring-up restarts cleanly.
                    if (lost_any) begin
                        fault_stage <= lost_idx;
                        stage_rst_n <= '0;
                        retry_cnt   <= '0;
                        idx         <= '0;
                        timer       <= '0;
                        all_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= HOLD;
                    end
                end
                FAULT: begin
                    stage_rst_n <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer for the driver board. It takes the board-level reset and releases a chain of downstream reset domains (clock/PLL, bus interface, motor drive, …) one at a time. Each stage must report ready before the next is released. A stage that never comes ready is retried a bounded number of times, then latched as a fault. The block sits directly behind the debounced board reset and drives the per-domain active-low resets.

## Interface

- N_STAGES, 4, number of sequenced reset domains (2..8)
- GAP_CYCLES, 16000, clkin cycles held between releases (1 ms at 16 MHz); ≥1
- ACK_TIMEOUT, 160000, clkin cycles allowed for a released stage to report ready; ≥4
- MAX_RETRIES, 3, automatic resequences before latching fault; ≥0

- clkin  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- soft_rst_req  in  1  single-cycle request to resequence from scratch (synchronous to clkin)
- stage_ready  in  N_STAGES  per-stage ready level; asynchronous, 2-flop synchronized internally (sync flops reset to 0)
- stage_rst_n  out  N_STAGES  per-stage active-low reset, registered
- all_ready  out  1  all stages released and ready
- busy  out  1  sequencing in progress
- fault  out  1  retries exhausted; latched
- fault_stage  out  $clog2(N_STAGES)  index of the most recent failing stage
- retry_cnt  out  $clog2(MAX_RETRIES+1) (min 1)  retries consumed in the current sequence

## Operation

- Reset values (async, while rst_n=0):
  - stage_rst_n=0, all_ready=0, busy=1, fault=0, fault_stage=0, retry_cnt=0
  - state HOLD, stage index 0, timer 0
- States: HOLD, RELEASE, WAIT_READY, GAP, RUN, FAULT.
- HOLD
  - All stage_rst_n=0.
  - Timer counts GAP_CYCLES cycles, then goes to RELEASE with index 0.
- RELEASE
  - Sets stage_rst_n[idx]=1.
  - Clears the timer and goes to WAIT_READY.
- WAIT_READY
  - If synced stage_ready[idx]=1: goes to RUN when idx==N_STAGES-1, otherwise to GAP.
  - Otherwise, when the timer reaches ACK_TIMEOUT-1, a failure is raised on idx.
- GAP
  - Counts GAP_CYCLES, then increments idx and goes to RELEASE.
- RUN
  - all_ready=1, busy=0.
- Failure (timeout, or synced ready of an already-acknowledged stage low in WAIT_READY/GAP):
  - fault_stage records the failing index. For ready-loss, this is the lowest-index stage whose ready dropped.
  - All stage_rst_n=0 on the next edge and idx=0.
  - If retry_cnt<MAX_RETRIES: retry_cnt+1, go to HOLD.
  - Otherwise: fault=1, go to FAULT.
- Ready-loss in RUN (any synced ready low)
  - fault_stage recorded, all stages asserted, retry_cnt cleared, go to HOLD.
  - fault is not set.
- FAULT
  - All stages held in reset, busy=0, all_ready=0.
  - Exits only via rst_n or soft_rst_req.
- soft_rst_req (any state, highest priority after rst_n)
  - Next edge: all stage_rst_n=0, all_ready=0, busy=1, fault=0, retry_cnt=0, timer 0, HOLD.
  - fault_stage is kept.
- stage_ready of stages not yet released is ignored.
- Timer width: $clog2(max(GAP_CYCLES, ACK_TIMEOUT)). The timer never wraps; it is cleared on every state entry.

## Timing

- Edge numbering: edge 1 is the first clkin rising edge with rst_n=1.
- stage_rst_n[0] rises at edge GAP_CYCLES.
- Ready latency: input change → synced value after 2 edges. The state acts on it at the 3rd edge.
- Ready already synced high on entering WAIT_READY: GAP is entered on the next edge.
- Stage k+1 release: exactly GAP_CYCLES+1 edges after stage k's release, when stage k was ready on entry.
- all_ready/busy: update on the edge after the last stage's ready is seen.
- Timeout: failure takes effect on edge ACK_TIMEOUT after RELEASE.
- Outputs change only on clkin edges, except the asynchronous assertion on rst_n.
- Simultaneous soft_rst_req and failure: soft_rst_req wins. retry_cnt=0, fault=0.

## Test plan

Params for all cases: N_STAGES=3, GAP_CYCLES=4, ACK_TIMEOUT=20, MAX_RETRIES=1.

- stage_ready=3'b111 held from reset → stage_rst_n=001 at edge 4, 011 at edge 9, 111 at edge 14; all_ready=1, busy=0 at edge 15.
- stage_ready[1] tied 0 → 20 cycles after stage1 release: stage_rst_n=000, retry_cnt=1, resequence. Second timeout → fault=1, fault_stage=1, stage_rst_n=000, busy=0, and the state stays there.
- In FAULT, pulse soft_rst_req → next edge fault=0, retry_cnt=0, busy=1; full sequence completes with ready fixed.
- In RUN, drop stage_ready[2] → 3 edges later stage_rst_n=000, all_ready=0, fault_stage=2, fault=0; sequence restarts.
- Drive rst_n=0 mid-WAIT_READY between edges → stage_rst_n=000, busy=1, all_ready=0 immediately without a clock. Release → sequence restarts from HOLD.
- soft_rst_req on the same edge as a timeout with retries exhausted → fault stays 0, retry_cnt=0, state HOLD.
